pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Soft-start / soft-reversal controller that sequences the 10-bit PWM duty word and the direction select feeding the PWM generator and H/G pulse steering. It converts the operator switch inputs (enable, full-power, direction) into a duty word that ramps at a fixed rate. On any direction reversal it ramps to zero, then holds a dead time before the direction flips, so the H and G outputs never switch while driven. It sits between the board switches and the PWM core, in the same clock domain as the PWM core.

Parameters:
W, 10, duty word width; full scale MAX = 2^W-1, half scale HALF = 2^(W-1)-1
STEP, 8, duty increment/decrement per ramp tick; must be 1..MAX
TICK_DIV, 50000, clk cycles per ramp tick; must be >= 1
DEAD_CYC, 1000, clk cycles duty is held at 0 before direction changes; must be >= 1

Ports:
clk  in  1  single clock; all logic is rising-edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run request (asynchronous switch); 0 = ramp to stop
full  in  1  power select (asynchronous switch); 1 = MAX, 0 = HALF
dir_req  in  1  requested direction (asynchronous switch); 1 = H side, 0 = G side
duty  out  W  duty word to the PWM core
dir  out  1  applied direction to the H/G steering
busy  out  1  high while ramping, draining or in dead time

Behaviour:
- Reset (rst_n=0, asynchronous): duty=0, dir=0, busy=0, state=RUN, prescaler=0, dead counter=0, synchroniser flops=0. All outputs are registered.
- en, full and dir_req each pass through a 2-flop synchroniser (en_s, full_s, dir_s). The core sees an input change 2 clk later.
- target = 0 if !en_s; MAX if full_s; HALF otherwise. Target is combinational from the synchronised inputs.
- Prescaler is free-running 0..TICK_DIV-1 and wraps. tick=1 for one clk when count==TICK_DIV-1. With TICK_DIV=1, tick is high every clk. The prescaler never resets except via rst_n.
- State RUN:
  - dir_s != dir and duty != 0 -> DRAIN (same clk; no duty update this clk).
  - dir_s != dir and duty == 0 -> DEAD, dead counter loaded with DEAD_CYC-1.
  - Otherwise on tick: if duty < target, duty = min(duty+STEP, target); if duty > target, duty = max(duty-STEP, target). The arithmetic uses W+1 bits, so there is no wrap and no overshoot.
- State DRAIN:
  - On tick, duty = duty - min(STEP, duty). The target is ignored.
  - duty == 0 (checked every clk) -> DEAD, counter loaded with DEAD_CYC-1.
  - dir_s == dir again before duty reaches 0 -> RUN (reversal aborted). dir never changes; ramping resumes toward the target.
- State DEAD:
  - duty is held at 0. The counter decrements every clk.
  - At counter == 0: dir <= dir_s, then -> RUN. If dir_s has returned to the old value, dir is rewritten unchanged.
  - The dead time is exactly DEAD_CYC clk from DEAD entry to the dir update.
- dir changes only on the DEAD -> RUN transition. duty is always 0 on the clk dir changes.
- busy = (state != RUN) or (duty != target). It is registered and updated together with duty.
- en_s=0 in RUN ramps duty down to 0 via the normal RUN rule. A reversal during the ramp-down still takes the DRAIN/DEAD path.
- Simultaneous target change and tick: the new target applies on that tick.
- rst_n asserted mid-ramp or mid-DEAD: duty=0 and dir=0 immediately (asynchronous). This is the one permitted dir change without dead time, because duty is 0.

Decomposition:
- Package pwm_ctrl_pkg holds:
  - state enum (RUN, DRAIN, DEAD) as a 2-bit typedef;
  - default W, STEP, TICK_DIV, DEAD_CYC;
  - helper constants MAX and HALF derived from W.
- One sub-module, pwm_tick_gen: prescaler with TICK_DIV parameter, ports clk, rst_n, tick. The 2-flop synchronisers are inline.

Test Plan (W=10, STEP=64, TICK_DIV=4, DEAD_CYC=3):
- Soft start: release reset, en=1 full=0 dir_req=0 -> after 2-clk sync, duty steps 64,128,...,448,511, one step every 4 clk; busy falls when duty=511; dir stays 0.
- Step to full: from 511 set full=1 -> duty 575,...,959,1023 then holds at 1023 (saturates, no wrap past 1023).
- Reversal: at duty=1023 set dir_req=1 -> DRAIN; duty decrements 64 per tick to 63 then 0 (16 ticks); dir=0 throughout; duty=0 for exactly 3 clk of DEAD; dir=1; duty ramps 64,128,... toward 1023.
- Aborted reversal: at duty=1023 set dir_req=1, then return it to 0 after 3 ticks -> duty bottoms at 831, ramps back to 1023; dir never leaves 0.
- Stop and reset: en=0 at duty=511 -> ramps to 0 by 64/tick, busy=0 at 0. Separately, assert rst_n mid-ramp at duty=320 -> duty=0 and dir=0 within the same clk (asynchronous).
- Prescaler: tick observed every 4 clk exactly, duty never changes between ticks in RUN or DRAIN; with TICK_DIV=1 the duty changes every clk.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default parameters for the PWM soft-start / soft-reversal controller.
package pwm_ctrl_pkg;

  localparam int unsigned DefW       = 10;
  localparam int unsigned DefStep    = 8;
  localparam int unsigned DefTickDiv = 50000;
  localparam int unsigned DefDeadCyc = 1000;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDead  = 2'd2
  } state_e;

  // All-ones value of a w-bit duty word.
  function automatic int unsigned max_duty(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned Max  = max_duty(DefW);
  localparam int unsigned Half = max_duty(DefW - 1);

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running prescaler producing a one-clk ramp tick every TICK_DIV clocks.
module pwm_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  assign tick = (count_q == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the PWM duty word toward the switch-selected target and sequences direction
// reversals through drain-to-zero and a dead time so H/G never switch while driven.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned W        = DefW,
  parameter int unsigned STEP     = DefStep,
  parameter int unsigned TICK_DIV = DefTickDiv,
  parameter int unsigned DEAD_CYC = DefDeadCyc
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         full,
  input  logic         dir_req,
  output logic [W-1:0] duty,
  output logic         dir,
  output logic         busy
);

  localparam logic [W:0] FullT = (W+1)'(max_duty(W));
  localparam logic [W:0] HalfT = (W+1)'(max_duty(W - 1));
  localparam logic [W:0] StepW = (W+1)'(STEP);
  localparam int unsigned DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DW-1:0] DeadInit = DW'(DEAD_CYC - 1);

  state_e        state_q, state_d;
  logic [2:0]    meta_q, sync_q;
  logic          en_s, full_s, dir_s;
  logic          tick;
  logic [W-1:0]  duty_q, duty_d;
  logic          dir_q, dir_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [W:0]    target, duty_x, up_w, dn_w;

  pwm_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {en, full, dir_req};
      sync_q <= meta_q;
    end
  end

  assign en_s   = sync_q[2];
  assign full_s = sync_q[1];
  assign dir_s  = sync_q[0];

  always_comb begin
    if (!en_s) begin
      target = '0;
    end else if (full_s) begin
      target = FullT;
    end else begin
      target = HalfT;
    end
  end

  // W+1-bit arithmetic keeps increments and decrements free of wrap-around.
  assign duty_x = {1'b0, duty_q};
  assign up_w   = duty_x + StepW;
  assign dn_w   = duty_x - StepW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (dir_s != dir_q) begin
          state_d = (duty_q != '0) ? StDrain : StDead;
        end
      end
      StDrain: begin
        if (duty_q == '0) begin
          state_d = StDead;
        end else if (dir_s == dir_q) begin
          state_d = StRun;
        end
      end
      StDead: begin
        if (dead_q == '0) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    dead_d = dead_q;
    unique case (state_q)
      StRun: begin
        if (dir_s != dir_q) begin
          if (duty_q == '0) begin
            dead_d = DeadInit;
          end
        end else if (tick) begin
          if (duty_x < target) begin
            duty_d = (up_w > target) ? target[W-1:0] : up_w[W-1:0];
          end else if (duty_x > target) begin
            duty_d = (dn_w < target || duty_x < StepW) ? target[W-1:0] : dn_w[W-1:0];
          end
        end
      end
      StDrain: begin
        if (duty_q == '0) begin
          dead_d = DeadInit;
        end else if (dir_s != dir_q && tick) begin
          duty_d = (duty_x <= StepW) ? '0 : dn_w[W-1:0];
        end
      end
      StDead: begin
        duty_d = '0;
        if (dead_q == '0) begin
          dir_d = dir_s;
        end else begin
          dead_d = dead_q - 1'b1;
        end
      end
      default: duty_d = duty_q;
    endcase
    busy_d = (state_d != StRun) || ({1'b0, duty_d} != target);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      dir_q  <= 1'b0;
      busy_q <= 1'b0;
      dead_q <= '0;
    end else begin
      duty_q <= duty_d;
      dir_q  <= dir_d;
      busy_q <= busy_d;
      dead_q <= dead_d;
    end
  end

  assign duty = duty_q;
  assign dir  = dir_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scenario bench for pwm_ramp_ctrl: expected duty/dir changes are queued per scenario and
// matched by a negedge monitor; a second instance with TICK_DIV=1 covers the per-clk ramp.
module tb_pwm_ramp_ctrl;

  localparam int unsigned W        = 10;
  localparam int unsigned STEP     = 64;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DEAD_CYC = 3;
  localparam int unsigned MAXV     = 1023;
  localparam int unsigned HALFV    = 511;

  logic         clk = 1'b0;
  logic         rst_n, en, full, dir_req;
  logic [W-1:0] duty;
  logic         dir, busy;
  logic         en1, full1, dir_req1;
  logic [W-1:0] duty1;
  logic         dir1, busy1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int unsigned exp_duty[$];
  logic        exp_dir[$];
  logic        mon_en = 1'b0;
  logic [W-1:0] prev_duty;
  logic        prev_dir;
  int          last_chg  = -1;
  int          zero_cyc  = 0;
  int          dirchg_cyc = 0;

  pwm_ramp_ctrl #(
    .W (W), .STEP (STEP), .TICK_DIV (TICK_DIV), .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk (clk), .rst_n (rst_n), .en (en), .full (full), .dir_req (dir_req),
    .duty (duty), .dir (dir), .busy (busy)
  );

  pwm_ramp_ctrl #(
    .W (W), .STEP (STEP), .TICK_DIV (1), .DEAD_CYC (DEAD_CYC)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .en (en1), .full (full1), .dir_req (dir_req1),
    .duty (duty1), .dir (dir1), .busy (busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every duty or dir change must match the head of its expectation queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (duty !== prev_duty) begin
        n_checks++;
        if (exp_duty.size() == 0) begin
          n_fail++;
          $display("FAIL duty_unexpected: got %0d, required no change from %0d", duty, prev_duty);
        end else begin
          int unsigned e;
          e = exp_duty.pop_front();
          if (duty !== W'(e)) begin
            n_fail++;
            $display("FAIL duty_seq: got %0d, required %0d", duty, e);
          end
        end
        if (last_chg >= 0) begin
          n_checks++;
          if (((cyc - last_chg) % TICK_DIV) != 0) begin
            n_fail++;
            $display("FAIL tick_spacing: gap %0d clk, required multiple of %0d",
                     cyc - last_chg, TICK_DIV);
          end
        end
        last_chg = cyc;
        if (duty == '0) zero_cyc = cyc;
        prev_duty = duty;
      end
      if (dir !== prev_dir) begin
        n_checks++;
        if (exp_dir.size() == 0) begin
          n_fail++;
          $display("FAIL dir_unexpected: got %0b, required %0b", dir, prev_dir);
        end else begin
          logic ed;
          ed = exp_dir.pop_front();
          if (dir !== ed) begin
            n_fail++;
            $display("FAIL dir_seq: got %0b, required %0b", dir, ed);
          end
        end
        n_checks++;
        if (duty !== '0) begin
          n_fail++;
          $display("FAIL dir_while_driven: duty %0d at dir change, required 0", duty);
        end
        dirchg_cyc = cyc;
        prev_dir = dir;
      end
    end
  end

  task automatic wait_clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Waits (bounded) until the duty queue holds at most 'left' entries.
  task automatic wait_queue(input int left, input int budget);
    for (int i = 0; i < budget && exp_duty.size() > left; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_ramp(input int unsigned from, input int unsigned to);
    int unsigned v;
    v = from;
    while (v != to) begin
      if (to > v) v = (v + STEP > to) ? to : v + STEP;
      else        v = (v < to + STEP) ? to : v - STEP;
      exp_duty.push_back(v);
    end
  endtask

  task automatic resync_monitor();
    prev_duty = duty;
    prev_dir  = dir;
    last_chg  = -1;
    mon_en    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; full = 1'b0; dir_req = 1'b0;
    en1 = 1'b0; full1 = 1'b0; dir_req1 = 1'b0;
    wait_clk(3);
    n_checks++;
    if (duty !== '0) begin n_fail++; $display("FAIL reset_duty: got %0d, required 0", duty); end
    n_checks++;
    if (dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %0b, required 0", dir); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    n_checks++;
    if (duty1 !== '0) begin n_fail++; $display("FAIL reset_duty1: got %0d, required 0", duty1); end
    rst_n = 1'b1;
    resync_monitor();
    wait_clk(6);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_soft_start();
    push_ramp(0, HALFV);
    en = 1'b1; full = 1'b0; dir_req = 1'b0;
    wait_queue(4, 200);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy_mid: got %0b, required 1", busy); end
    wait_queue(0, 200);
    n_checks++;
    if (exp_duty.size() != 0) begin
      n_fail++; $display("FAIL start_timeout: %0d changes missing, required 0", exp_duty.size());
      exp_duty.delete();
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_busy_end: got %0b, required 0", busy); end
    n_checks++;
    if (dir !== 1'b0) begin n_fail++; $display("FAIL start_dir: got %0b, required 0", dir); end
  endtask

  task automatic test_full();
    push_ramp(HALFV, MAXV);
    full = 1'b1;
    wait_queue(0, 200);
    n_checks++;
    if (exp_duty.size() != 0) begin
      n_fail++; $display("FAIL full_timeout: %0d changes missing, required 0", exp_duty.size());
      exp_duty.delete();
    end
    wait_clk(20);
    n_checks++;
    if (duty !== W'(MAXV)) begin n_fail++; $display("FAIL full_hold: got %0d, required %0d", duty, MAXV); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_reversal();
    push_ramp(MAXV, 0);
    exp_dir.push_back(1'b1);
    push_ramp(0, MAXV);
    dir_req = 1'b1;
    wait_queue(16, 300);
    n_checks++;
    if (busy !== 1'b1 || dir !== 1'b0) begin
      n_fail++; $display("FAIL rev_drain_state: busy %0b dir %0b, required busy 1 dir 0", busy, dir);
    end
    wait_queue(0, 400);
    n_checks++;
    if (exp_duty.size() != 0 || exp_dir.size() != 0) begin
      n_fail++;
      $display("FAIL rev_timeout: %0d duty / %0d dir changes missing, required 0",
               exp_duty.size(), exp_dir.size());
      exp_duty.delete(); exp_dir.delete();
    end
    // One DRAIN clk observes duty==0, then DEAD_CYC clk of dead time.
    n_checks++;
    if (dirchg_cyc - zero_cyc != DEAD_CYC + 1) begin
      n_fail++; $display("FAIL rev_dead_time: got %0d clk, required %0d",
                         dirchg_cyc - zero_cyc, DEAD_CYC + 1);
    end
    n_checks++;
    if (dir !== 1'b1) begin n_fail++; $display("FAIL rev_dir: got %0b, required 1", dir); end
  endtask

  task automatic test_abort();
    push_ramp(MAXV, MAXV - 3 * STEP);
    push_ramp(MAXV - 3 * STEP, MAXV);
    dir_req = 1'b0;
    wait_queue(3, 200);
    dir_req = 1'b1;
    wait_queue(0, 200);
    n_checks++;
    if (exp_duty.size() != 0) begin
      n_fail++; $display("FAIL abort_timeout: %0d changes missing, required 0", exp_duty.size());
      exp_duty.delete();
    end
    wait_clk(12);
    n_checks++;
    if (dir !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_end: dir %0b busy %0b, required dir 1 busy 0", dir, busy);
    end
  endtask

  task automatic test_stop();
    push_ramp(MAXV, HALFV);
    full = 1'b0;
    wait_queue(0, 200);
    push_ramp(HALFV, 0);
    en = 1'b0;
    wait_queue(0, 200);
    n_checks++;
    if (exp_duty.size() != 0) begin
      n_fail++; $display("FAIL stop_timeout: %0d changes missing, required 0", exp_duty.size());
      exp_duty.delete();
    end
    n_checks++;
    if (duty !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stop_end: duty %0d busy %0b, required 0 0", duty, busy);
    end
  endtask

  task automatic test_reset_mid();
    push_ramp(0, 5 * STEP);
    en = 1'b1; full = 1'b1;
    wait_queue(0, 200);
    n_checks++;
    if (duty !== W'(5 * STEP) || dir !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: duty %0d dir %0b, required %0d 1", duty, dir, 5 * STEP);
    end
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (duty !== '0 || dir !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: duty %0d dir %0b busy %0b, required 0 0 0",
                         duty, dir, busy);
    end
    en = 1'b0; full = 1'b0; dir_req = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    resync_monitor();
    wait_clk(10);
    n_checks++;
    if (duty !== '0 || dir !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: duty %0d dir %0b, required 0 0", duty, dir);
    end
  endtask

  task automatic test_tick_div1();
    int unsigned e;
    int i;
    en1 = 1'b1; full1 = 1'b1; dir_req1 = 1'b0;
    i = 0;
    while (i < 10 && duty1 == '0) begin
      wait_clk(1);
      i++;
    end
    for (int k = 1; k <= 16; k++) begin
      e = (k * STEP > MAXV) ? MAXV : k * STEP;
      n_checks++;
      if (duty1 !== W'(e)) begin
        n_fail++; $display("FAIL div1_step%0d: got %0d, required %0d", k, duty1, e);
      end
      wait_clk(1);
    end
    n_checks++;
    if (duty1 !== W'(MAXV) || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL div1_hold: duty %0d busy %0b, required %0d 0", duty1, busy1, MAXV);
    end
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_full();
    test_reversal();
    test_abort();
    test_stop();
    test_reset_mid();
    test_tick_div1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
